// File: rtl/uart_block_assembler.sv
// Packs UART receive bytes into one SHA-256 message block (first byte at the MSB end)
// and offers it downstream on a valid/ready handshake. Stalled partial blocks are discarded.
module uart_block_assembler #(
    parameter int BLOCK_BYTES    = 64,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int CNT_W          = 7
) (
    input  logic                     CLK100MHZ,
    input  logic                     CPU_RESETN,
    input  logic [7:0]               RX_DATA,
    input  logic                     RX_STB,
    output logic [8*BLOCK_BYTES-1:0] BLK_DATA,
    output logic                     BLK_VALID,
    input  logic                     BLK_READY,
    output logic [CNT_W-1:0]         BYTE_CNT,
    output logic                     OVERRUN,
    output logic                     TIMEOUT
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BLOCK_BYTES);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [8*BLOCK_BYTES-1:0] data_q, data_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;
    logic [IDLE_W-1:0]        idle_q, idle_d;

    // Next-state logic: byte capture, block hand-off, overrun flag and idle timeout.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        timeout_d = 1'b0;
        idle_d    = idle_q;
        case (state_q)
            ST_FILL: begin
                if (RX_STB) begin
                    for (int k = 0; k < BLOCK_BYTES; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            data_d[8*(BLOCK_BYTES-1-k) +: 8] = RX_DATA;
                        end else begin
                            data_d[8*(BLOCK_BYTES-1-k) +: 8] = data_d[8*(BLOCK_BYTES-1-k) +: 8];
                        end
                    end
                    idle_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_FULL;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (cnt_q != '0) begin
                    // A strobe on the final idle count takes the branch above, so it always wins.
                    if (idle_q == IDLE_LAST) begin
                        cnt_d     = '0;
                        data_d    = '0;
                        idle_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_ONE;
                    end
                end else begin
                    idle_d = '0;
                end
            end
            ST_HOLD: begin
                idle_d = '0;
                if (RX_STB) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (BLK_READY) begin
                    state_d = ST_FILL;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_FILL;
                valid_d = 1'b0;
                cnt_d   = '0;
                idle_d  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= ST_FILL;
            data_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
        end
    end

    assign BLK_DATA  = data_q;
    assign BLK_VALID = valid_q;
    assign BYTE_CNT  = cnt_q;
    assign OVERRUN   = overrun_q;
    assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Self-checking bench for uart_block_assembler: vector table, directed corner cases and
// a randomized run compared every cycle against a queue-based reference model.
module tb_uart_block_assembler;

    localparam int BB = 64;
    localparam int TO = 100;
    localparam int CW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      rx_data;
    logic            rx_stb;
    logic            blk_ready;
    logic [8*BB-1:0] blk_data;
    logic            blk_valid;
    logic [CW-1:0]   byte_cnt;
    logic            overrun;
    logic            timeout;

    always #5 clk = ~clk;

    uart_block_assembler #(
        .BLOCK_BYTES   (BB),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .RX_DATA   (rx_data),
        .RX_STB    (rx_stb),
        .BLK_DATA  (blk_data),
        .BLK_VALID (blk_valid),
        .BLK_READY (blk_ready),
        .BYTE_CNT  (byte_cnt),
        .OVERRUN   (overrun),
        .TIMEOUT   (timeout)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: the bytes of the block in progress, plus the visible data image.
    byte unsigned    m_q[$];
    bit              m_held, m_ovr, m_to;
    int              m_idle;
    logic [8*BB-1:0] m_blk;
    logic [8*BB-1:0] xfer[$];

    typedef struct {
        bit         stb;
        logic [7:0] d;
        bit         rdy;
        bit         e_valid;
        logic [6:0] e_cnt;
        bit         e_ovr;
        bit         e_to;
        logic [7:0] e_top;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else passed++;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_held = 1'b0;
        m_ovr  = 1'b0;
        m_to   = 1'b0;
        m_idle = 0;
        m_blk  = '0;
    endtask

    task automatic model_step(input bit stb, input byte unsigned d, input bit rdy);
        m_to = 1'b0;
        if (m_held) begin
            if (stb) m_ovr = 1'b1;
            if (rdy) begin
                m_held = 1'b0;
                m_q.delete();
            end
            m_idle = 0;
        end else if (stb) begin
            m_blk[8*(BB-1-m_q.size()) +: 8] = d;
            m_q.push_back(d);
            m_idle = 0;
            if (m_q.size() == BB) m_held = 1'b1;
        end else if (m_q.size() > 0) begin
            if (m_idle == TO-1) begin
                m_q.delete();
                m_blk  = '0;
                m_idle = 0;
                m_to   = 1'b1;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    function automatic logic [527:0] pack_dut();
        return {6'd0, blk_data, blk_valid, byte_cnt, overrun, timeout};
    endfunction

    function automatic logic [527:0] pack_model();
        return {6'd0, m_blk, m_held, 7'(m_q.size()), m_ovr, m_to};
    endfunction

    task automatic cyc(input bit stb, input logic [7:0] d, input bit rdy);
        rx_stb    = stb;
        rx_data   = d;
        blk_ready = rdy;
        if (blk_valid && rdy) xfer.push_back(blk_data);
        @(posedge clk);
        #1;
        model_step(stb, d, rdy);
        chk("model", pack_dut(), pack_model());
        rx_stb    = 1'b0;
        blk_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rx_stb    = 1'b0;
        rx_data   = 8'h00;
        blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n;
        bit saw_to;
        int mode;
        bit stb;
        bit rdy;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 8'hA5};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0, 8'hA5};
        tbl[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 7'd2, 1'b0, 1'b0, 8'hA5};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0, 8'hA5};
        tbl[4] = '{1'b1, 8'h01, 1'b0, 1'b0, 7'd3, 1'b0, 1'b0, 8'hA5};

        do_reset();
        chk("reset state", pack_dut(), 528'd0);

        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].stb, tbl[i].d, tbl[i].rdy);
            chk("table", {blk_valid, byte_cnt, overrun, timeout, blk_data[511:504]},
                {tbl[i].e_valid, tbl[i].e_cnt, tbl[i].e_ovr, tbl[i].e_to, tbl[i].e_top});
        end

        // Basic fill, strobes spaced 10 cycles apart.
        do_reset();
        for (int i = 0; i < BB; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i < BB-1) repeat (9) cyc(1'b0, 8'h00, 1'b0);
        end
        chk("fill valid/cnt", {blk_valid, byte_cnt}, {1'b1, 7'd64});
        chk("fill first byte", blk_data[511:504], 8'h00);
        chk("fill last byte", blk_data[7:0], 8'h3F);

        // Hold with BLK_READY low, then a single-cycle transfer.
        begin
            logic [8*BB-1:0] saved;
            saved = blk_data;
            for (int i = 0; i < 50; i++) begin
                cyc(1'b0, 8'h00, 1'b0);
                chk("hold data", blk_data, saved);
            end
            cyc(1'b0, 8'h00, 1'b1);
            chk("after xfer valid/cnt", {blk_valid, byte_cnt}, {1'b0, 7'd0});
            chk("after xfer data kept", blk_data, saved);
        end

        // Back-to-back, strobe every 2 cycles, ready tied high.
        xfer.delete();
        for (int i = 0; i < 2*BB; i++) begin
            cyc(1'b1, 8'(i), 1'b1);
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("b2b block count", xfer.size(), 2);
        if (xfer.size() == 2) begin
            chk("b2b blk0 last", xfer[0][7:0], 8'h3F);
            chk("b2b blk1 first", xfer[1][511:504], 8'h40);
        end
        chk("b2b no overrun", overrun, 1'b0);

        // Strobe every cycle: byte 64 lands on the transfer cycle and is dropped.
        for (int i = 0; i < BB+2; i++) cyc(1'b1, 8'(i), 1'b1);
        chk("overrun set", overrun, 1'b1);
        chk("after drop cnt", byte_cnt, 7'd1);
        chk("after drop lane0", blk_data[511:504], 8'd65);

        // Timeout of a 5-byte partial block.
        do_reset();
        repeat (5) cyc(1'b1, 8'hAA, 1'b0);
        n = 0;
        while (!timeout && n < 200) begin
            cyc(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("timeout latency", n, 100);
        chk("timeout cnt/data", {byte_cnt, blk_data}, '0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("timeout one pulse", timeout, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        chk("post-timeout lane0", {byte_cnt, blk_data[511:504]}, {7'd1, 8'h11});

        // Strobe on the final idle count wins over the timeout.
        saw_to = 1'b0;
        repeat (99) begin
            cyc(1'b0, 8'h00, 1'b0);
            saw_to |= timeout;
        end
        cyc(1'b1, 8'h22, 1'b0);
        saw_to |= timeout;
        chk("race no timeout", saw_to, 1'b0);
        chk("race cnt", byte_cnt, 7'd2);

        // Asynchronous reset mid-clock with overrun set and 30 bytes held.
        do_reset();
        for (int i = 0; i < BB; i++) cyc(1'b1, 8'(i + 1), 1'b0);
        cyc(1'b1, 8'hEE, 1'b0);
        chk("hold overrun", overrun, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 30; i++) cyc(1'b1, 8'(i + 7), 1'b0);
        chk("30 bytes held", byte_cnt, 7'd30);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", pack_dut(), 528'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 8'h5A, 1'b0);
        chk("post-reset lane0", {byte_cnt, blk_data[511:504]}, {7'd1, 8'h5A});

        // Randomized traffic in phases of different strobe density.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            mode = (i / 250) % 4;
            case (mode)
                0:       stb = ($urandom_range(0, 1) == 0);
                1:       stb = ($urandom_range(0, 7) != 0);
                2:       stb = ($urandom_range(0, 59) == 0);
                default: stb = ($urandom_range(0, 3) == 0);
            endcase
            rdy = ($urandom_range(0, 3) == 0);
            cyc(stb, 8'($urandom), rdy);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_block_assembler.md
Name: uart_block_assembler

Overview:
- Sits directly downstream of the UART receiver in the SHAVADER datapath.
- Collects received bytes into one 512-bit SHA-256 message block and presents it to the hash core over a valid/ready handshake.
- Discards a partial block if the PC stalls mid-block (inter-byte timeout).
- Flags bytes that arrive while a completed block is still waiting to be consumed.

Parameters:
- BLOCK_BYTES, 64, number of bytes per output block (BLK_DATA width = 8*BLOCK_BYTES).
- TIMEOUT_CYCLES, 10000000, idle clocks between bytes of a partial block before it is discarded (100 ms at 100 MHz).
- CNT_W, 7, width of BYTE_CNT; must hold the value BLOCK_BYTES.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz, all logic on rising edge.
- CPU_RESETN  input  1  asynchronous active-low reset.
- RX_DATA  input  8  received byte from the UART receiver.
- RX_STB  input  1  one-cycle pulse; RX_DATA is valid in this cycle.
- BLK_DATA  output  512  assembled block; first received byte in [511:504], last byte in [7:0].
- BLK_VALID  output  1  a complete block is held on BLK_DATA.
- BLK_READY  input  1  hash core accepts the block when high together with BLK_VALID.
- BYTE_CNT  output  CNT_W  number of bytes currently held (0..BLOCK_BYTES).
- OVERRUN  output  1  sticky flag: at least one byte was dropped.
- TIMEOUT  output  1  one-cycle pulse when a partial block is discarded.

Behaviour:
- Reset (CPU_RESETN low, asynchronous):
  - State FILL.
  - BLK_DATA = 0, BLK_VALID = 0, BYTE_CNT = 0, OVERRUN = 0, TIMEOUT = 0.
  - Idle counter = 0.
- FILL state:
  - On RX_STB: byte is written to byte lane BYTE_CNT, counting from the MSB end (lane k occupies bits [511-8k : 504-8k]). BYTE_CNT increments and the idle counter clears.
  - When the byte written is lane BLOCK_BYTES-1: next cycle is state HOLD, BYTE_CNT = 64, BLK_VALID = 1.
  - Latency: RX_STB of the final byte at cycle N gives BLK_VALID high at cycle N+1.
- HOLD state:
  - BLK_DATA and BYTE_CNT are frozen.
  - BLK_VALID stays 1 until a cycle where BLK_READY = 1 (transfer).
  - Cycle after transfer: BLK_VALID = 0, BYTE_CNT = 0, state FILL. BLK_DATA keeps its last value until it is overwritten.
  - BLK_READY while BLK_VALID = 0 is ignored.
- Overrun:
  - RX_STB in HOLD, including the transfer cycle itself, drops the byte and sets OVERRUN.
  - OVERRUN clears only on reset.
- Timeout:
  - Applies only in FILL with BYTE_CNT > 0.
  - The idle counter increments on every cycle without RX_STB.
  - When it reaches TIMEOUT_CYCLES-1, the next cycle has: BYTE_CNT = 0, BLK_DATA = 0, idle counter = 0, TIMEOUT = 1 for exactly one cycle.
  - RX_STB in the same cycle the count reaches TIMEOUT_CYCLES-1 wins: the byte is stored and no timeout occurs.
  - The idle counter is held at 0 when BYTE_CNT = 0 and in HOLD.
- Mid-operation reset: a partial or held block is lost; the first byte after reset goes to lane 0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Basic fill: reset, then 64 RX_STB pulses with RX_DATA = 0x00..0x3F spaced 10 cycles apart, BLK_READY = 0 -> BLK_VALID rises 1 cycle after the 64th strobe, BLK_DATA[511:504] = 0x00, BLK_DATA[7:0] = 0x3F, BYTE_CNT = 64.
- Handshake hold: from the held block, keep BLK_READY low 50 cycles, then pulse it for 1 cycle -> BLK_DATA unchanged for all 50 cycles; BLK_VALID = 0 and BYTE_CNT = 0 on the next cycle.
- Back-to-back: send 128 bytes with RX_STB every 2 cycles, BLK_READY tied high -> two blocks delivered, second block's [511:504] = byte 64, OVERRUN = 0. Then repeat with RX_STB every cycle -> byte 64 arrives on the transfer cycle and is dropped, OVERRUN = 1.
- Timeout (TIMEOUT_CYCLES = 100 in sim): send 5 bytes 0xAA, then idle -> TIMEOUT pulses 100 cycles after the 5th strobe, BYTE_CNT = 0, BLK_DATA = 0. A following 0x11 lands in [511:504].
- Timeout race: strobe a byte exactly at idle count 99 -> no TIMEOUT, BYTE_CNT increments.
- Async reset: assert CPU_RESETN low mid-clock with 30 bytes held -> all outputs 0 immediately, before the next clock edge; OVERRUN cleared.
